// File: rtl/servo_sweep_controller.sv
// Servo sweep sequencer: steps a triangular position pattern, settles, triggers one
// sensor measurement per position, and logs each result (or a timeout).
module servo_sweep_controller #(
    parameter int N_POS     = 14,
    parameter int W         = 3,
    parameter int T_SETTLE  = 4,
    parameter int T_TIMEOUT = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         ligar,
    input  logic         pronto,
    output logic [W-1:0] posicao,
    output logic         medir,
    output logic         registra,
    output logic         erro_timeout,
    output logic         fim_ciclo,
    output logic [3:0]   db_estado
);

    localparam int IW = (N_POS > 1)     ? $clog2(N_POS)     : 1;
    localparam int SW = (T_SETTLE > 1)  ? $clog2(T_SETTLE)  : 1;
    localparam int TW = (T_TIMEOUT > 1) ? $clog2(T_TIMEOUT) : 1;

    localparam logic [IW-1:0] IDX_LAST    = IW'(N_POS - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(T_SETTLE - 1);
    localparam logic [TW-1:0] TOUT_LAST   = TW'(T_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_POSICIONA = 4'd1,
        S_ESPERA    = 4'd2,
        S_MEDE      = 4'd3,
        S_AGUARDA   = 4'd4,
        S_REGISTRA  = 4'd5,
        S_PROXIMO   = 4'd6
    } state_t;

    state_t        state_reg, state_next;
    logic [IW-1:0] index_reg, index_next;
    logic [W-1:0]  posicao_reg, posicao_next;
    logic [SW-1:0] settle_cnt_reg, settle_cnt_next;
    logic [TW-1:0] tout_cnt_reg, tout_cnt_next;
    logic          tout_flag_reg, tout_flag_next;
    logic          medir_reg, medir_next;
    logic          registra_reg, registra_next;
    logic          erro_reg, erro_next;
    logic          fim_reg, fim_next;

    // Triangular position map: rises to N_POS/2, then mirrors back down.
    logic [W-1:0] pos_table [N_POS];

    generate
        for (genvar gi = 0; gi < N_POS; gi++) begin : g_pos_map
            localparam int P = (gi <= N_POS / 2) ? gi : N_POS - gi;
            assign pos_table[gi] = W'(P);
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        index_next      = index_reg;
        posicao_next    = posicao_reg;
        settle_cnt_next = settle_cnt_reg;
        tout_cnt_next   = tout_cnt_reg;
        tout_flag_next  = tout_flag_reg;

        case (state_reg)
            S_IDLE: begin
                if (ligar) begin
                    state_next = S_POSICIONA;
                end
            end
            S_POSICIONA: begin
                posicao_next    = pos_table[index_reg];
                settle_cnt_next = '0;
                state_next      = S_ESPERA;
            end
            S_ESPERA: begin
                settle_cnt_next = settle_cnt_reg + SW'(1);
                if (settle_cnt_reg == SETTLE_LAST) begin
                    state_next = S_MEDE;
                end
            end
            S_MEDE: begin
                tout_cnt_next = '0;
                state_next    = S_AGUARDA;
            end
            S_AGUARDA: begin
                tout_cnt_next = tout_cnt_reg + TW'(1);
                // A result arriving on the terminal-count cycle still counts as on time.
                if (pronto) begin
                    tout_flag_next = 1'b0;
                    state_next     = S_REGISTRA;
                end else if (tout_cnt_reg == TOUT_LAST) begin
                    tout_flag_next = 1'b1;
                    state_next     = S_REGISTRA;
                end
            end
            S_REGISTRA: begin
                state_next = S_PROXIMO;
            end
            S_PROXIMO: begin
                index_next = (index_reg == IDX_LAST) ? '0 : index_reg + IW'(1);
                state_next = ligar ? S_POSICIONA : S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Pulses are decoded from the next state so they line up with the state they belong to.
    always_comb begin
        medir_next    = (state_next == S_MEDE);
        registra_next = (state_next == S_REGISTRA);
        erro_next     = (state_next == S_REGISTRA) && tout_flag_next;
        fim_next      = (state_next == S_PROXIMO) && (index_reg == IDX_LAST);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            index_reg      <= '0;
            posicao_reg    <= '0;
            settle_cnt_reg <= '0;
            tout_cnt_reg   <= '0;
            tout_flag_reg  <= 1'b0;
            medir_reg      <= 1'b0;
            registra_reg   <= 1'b0;
            erro_reg       <= 1'b0;
            fim_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            index_reg      <= index_next;
            posicao_reg    <= posicao_next;
            settle_cnt_reg <= settle_cnt_next;
            tout_cnt_reg   <= tout_cnt_next;
            tout_flag_reg  <= tout_flag_next;
            medir_reg      <= medir_next;
            registra_reg   <= registra_next;
            erro_reg       <= erro_next;
            fim_reg        <= fim_next;
        end
    end

    assign posicao      = posicao_reg;
    assign medir        = medir_reg;
    assign registra     = registra_reg;
    assign erro_timeout = erro_reg;
    assign fim_ciclo    = fim_reg;
    assign db_estado    = state_reg;

endmodule

// File: tb/tb_servo_sweep_controller.sv
// Scoreboard bench for servo_sweep_controller: the driver schedules each step from the
// timing rules, queues the expected pulses, and a negedge monitor matches what the DUT emits.
module tb_servo_sweep_controller;

    localparam int N_POS     = 14;
    localparam int W         = 3;
    localparam int T_SETTLE  = 4;
    localparam int T_TIMEOUT = 8;

    logic         clock;
    logic         reset;
    logic         ligar;
    logic         pronto;
    logic [W-1:0] posicao;
    logic         medir;
    logic         registra;
    logic         erro_timeout;
    logic         fim_ciclo;
    logic [3:0]   db_estado;

    servo_sweep_controller #(
        .N_POS    (N_POS),
        .W        (W),
        .T_SETTLE (T_SETTLE),
        .T_TIMEOUT(T_TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .ligar       (ligar),
        .pronto      (pronto),
        .posicao     (posicao),
        .medir       (medir),
        .registra    (registra),
        .erro_timeout(erro_timeout),
        .fim_ciclo   (fim_ciclo),
        .db_estado   (db_estado)
    );

    typedef struct {
        int cyc;
        int pos;
        int erro;
    } rec_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   mon_en = 1'b0;
    int   model_idx = 0;
    int   exp_medir[$];
    int   exp_fim[$];
    rec_t exp_rec[$];
    int   mon_c;
    rec_t mon_r;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void check(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic int pos_of(int idx);
        return (idx <= N_POS / 2) ? idx : N_POS - idx;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One full step starting in a cycle where the DUT samples ligar (IDLE or PROXIMO).
    // d = cycles after medir at which pronto is pulsed; d > T_TIMEOUT means never.
    task automatic do_step(input int d, input bit noise, input bit keep);
        int   s, m, r, ep;
        bit   tmo;
        rec_t e;
        s   = cyc;
        m   = s + 2 + T_SETTLE;
        tmo = (d > T_TIMEOUT);
        r   = tmo ? m + T_TIMEOUT + 1 : m + d + 1;
        ep  = pos_of(model_idx);
        exp_medir.push_back(m);
        e.cyc = r; e.pos = ep; e.erro = tmo ? 1 : 0;
        exp_rec.push_back(e);
        if (model_idx == N_POS - 1) exp_fim.push_back(r + 1);
        model_idx = (model_idx + 1) % N_POS;
        for (int cur = s; cur <= r + 1; cur++) begin
            if (cur == s + 2) check("posicao_load", int'(posicao), ep);
            if (!tmo && cur == m + d) pronto = 1'b1;
            else if (noise && (cur <= m || cur >= r)) pronto = ($urandom_range(0, 3) == 0);
            else pronto = 1'b0;
            if (cur == s) ligar = 1'b1;
            else if (cur == r + 1) ligar = keep;
            else if (noise) ligar = 1'($urandom_range(0, 1));
            else if (!keep && cur >= s + 3) ligar = 1'b0;
            if (cur < r + 1) tick();
        end
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            if (medir) begin
                if (exp_medir.size() == 0) check("medir_unexpected", 1, 0);
                else begin
                    mon_c = exp_medir.pop_front();
                    check("medir_cycle", cyc, mon_c);
                end
            end
            if (registra) begin
                $display("rec cyc=%0d posicao=%0d erro_timeout=%0d", cyc, posicao, erro_timeout);
                if (exp_rec.size() == 0) check("registra_unexpected", 1, 0);
                else begin
                    mon_r = exp_rec.pop_front();
                    check("registra_cycle", cyc, mon_r.cyc);
                    check("registra_posicao", int'(posicao), mon_r.pos);
                    check("registra_erro", int'(erro_timeout), mon_r.erro);
                end
            end else if (erro_timeout) begin
                check("erro_without_registra", 1, 0);
            end
            if (fim_ciclo) begin
                if (exp_fim.size() == 0) check("fim_unexpected", 1, 0);
                else begin
                    mon_c = exp_fim.pop_front();
                    check("fim_cycle", cyc, mon_c);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, m;
        reset  = 1'b1;
        ligar  = 1'b0;
        pronto = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        mon_en = 1'b1;
        check("reset_posicao", int'(posicao), 0);
        check("reset_medir", int'(medir), 0);
        check("reset_registra", int'(registra), 0);
        check("reset_erro", int'(erro_timeout), 0);
        check("reset_fim", int'(fim_ciclo), 0);
        check("reset_estado", int'(db_estado), 0);
        tick();
        check("idle_hold", int'(db_estado), 0);

        // Start latency and a full sweep with pronto 3 cycles after medir, plus one wrap.
        for (int i = 0; i < N_POS + 1; i++) do_step(3, 1'b0, 1'b1);

        // Randomized pronto timing with pronto/ligar noise outside the sampled windows.
        for (int i = 0; i < 25; i++) do_step($urandom_range(1, T_TIMEOUT + 3), 1'b1, 1'b1);

        // Stop at posicao 3, then resume at 4.
        while (model_idx != 3) do_step($urandom_range(1, T_TIMEOUT + 3), 1'b1, 1'b1);
        do_step(2, 1'b0, 1'b0);
        tick();
        check("stop_estado", int'(db_estado), 0);
        check("stop_posicao", int'(posicao), 3);
        for (int i = 0; i < 3; i++) begin
            pronto = ($urandom_range(0, 1) == 1);
            tick();
        end
        pronto = 1'b0;
        check("idle_posicao_held", int'(posicao), 3);
        do_step(1, 1'b0, 1'b1);

        // Reset while waiting for the measurement at posicao 5.
        while (model_idx != 5) do_step($urandom_range(1, T_TIMEOUT), 1'b1, 1'b1);
        s = cyc;
        m = s + 2 + T_SETTLE;
        exp_medir.push_back(m);
        ligar  = 1'b1;
        pronto = 1'b0;
        while (cyc < m + 2) tick();
        check("pre_reset_estado", int'(db_estado), 4);
        check("pre_reset_posicao", int'(posicao), 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ligar = 1'b0;
        check("midreset_estado", int'(db_estado), 0);
        check("midreset_posicao", int'(posicao), 0);
        check("midreset_registra", int'(registra), 0);
        model_idx = 0;
        for (int i = 0; i < 12; i++) begin
            pronto = ($urandom_range(0, 2) == 0);
            tick();
        end
        pronto = 1'b0;
        check("post_reset_idle", int'(db_estado), 0);

        // Restart from index 0, then pronto on the terminal cycle, then a clean timeout.
        do_step(2, 1'b1, 1'b1);
        do_step(T_TIMEOUT, 1'b0, 1'b1);
        do_step(T_TIMEOUT + 1, 1'b0, 1'b0);
        pronto = 1'b0;
        repeat (4) tick();
        check("end_estado", int'(db_estado), 0);
        check("medir_pending", exp_medir.size(), 0);
        check("registra_pending", exp_rec.size(), 0);
        check("fim_pending", exp_fim.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
